// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: 2-flop input sync, mid-bit sampling, parity and framing flags.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting around the mid-bit sample point.
//
// state   | meaning
// IDLE    | line idle, waiting for rx_s low
// START   | validating start bit at sample point
// DATA    | sampling data bits, LSB first
// PARITY  | sampling and checking parity bit
// STOP    | sampling stop bit(s), frame completes here
// RECOVER | after framing error/break, wait for line high
module uart_rx_frame #(
  parameter int NDATA_BITS   = 8,
  parameter int NSTOP_BITS   = 1,
  parameter int PARITY_MODE  = 0,
  parameter int OVERSAMPLING = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_baud,
  input  logic                  i_rx,
  output logic [NDATA_BITS-1:0] o_data,
  output logic                  o_rx_done,
  output logic                  o_parity_err,
  output logic                  o_frame_err
);

  localparam int TW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(NDATA_BITS);
  localparam bit PAR_EN  = (PARITY_MODE == 1) || (PARITY_MODE == 2);
  localparam bit PAR_ODD = (PARITY_MODE == 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int SAMPLE_AT = OVERSAMPLING / 2;
`else
  localparam int SAMPLE_AT = OVERSAMPLING / 2 - 1;
`endif
  localparam logic [TW-1:0] SAMPLE_T = TW'(SAMPLE_AT);
  localparam logic [TW-1:0] LAST_T   = TW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NDATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, RECOVER} state_t;

  state_t                  state, state_nx;
  logic [TW-1:0]           tick_cnt, tick_nx;
  logic [BW-1:0]           bit_cnt, bit_nx;
  logic                    stop_cnt, stop_nx;
  logic [NDATA_BITS-1:0]   shift_r, shift_nx;
  logic                    perr_r, perr_nx;
  logic                    rx_m, rx_s;
  logic                    done, ferr;
  logic                    sample_pt, bit_end, bit_val;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
    end
  end

  assign sample_pt = i_baud && (tick_cnt == SAMPLE_T);
  assign bit_end   = i_baud && (tick_cnt == LAST_T);

`ifdef UART_RX_MAJORITY_EN
  logic vote_a, vote_b;

  // Votes are captured one and two ticks ahead of the decision tick.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else if (i_baud) begin
      if (tick_cnt == TW'(OVERSAMPLING / 2 - 2)) vote_a <= rx_s;
      if (tick_cnt == TW'(OVERSAMPLING / 2 - 1)) vote_b <= rx_s;
    end
  end

  assign bit_val = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_comb begin
    state_nx = state;
    tick_nx  = tick_cnt;
    bit_nx   = bit_cnt;
    stop_nx  = stop_cnt;
    shift_nx = shift_r;
    perr_nx  = perr_r;
    done     = 1'b0;
    ferr     = 1'b0;
    if (i_baud && state != IDLE && state != RECOVER)
      tick_nx = bit_end ? '0 : tick_cnt + 1'b1;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nx = START;
          tick_nx  = '0;
        end
      end
      START: begin
        if (sample_pt && bit_val) begin
          state_nx = IDLE;
          tick_nx  = '0;
        end else if (bit_end) begin
          state_nx = DATA;
          bit_nx   = '0;
          perr_nx  = 1'b0;
        end
      end
      DATA: begin
        if (sample_pt) shift_nx[bit_cnt] = bit_val;
        if (bit_end) begin
          if (bit_cnt == BIT_LAST) begin
            state_nx = PAR_EN ? PARITY : STOP;
            stop_nx  = 1'b0;
          end else begin
            bit_nx = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (sample_pt) perr_nx = (^shift_r) ^ bit_val ^ PAR_ODD;
        if (bit_end) begin
          state_nx = STOP;
          stop_nx  = 1'b0;
        end
      end
      STOP: begin
        // Completing at the sample point leaves half a bit to re-sync on the next start edge.
        if (sample_pt) begin
          if (!bit_val) begin
            done     = 1'b1;
            ferr     = 1'b1;
            state_nx = RECOVER;
            tick_nx  = '0;
          end else if (NSTOP_BITS == 1 || stop_cnt) begin
            done     = 1'b1;
            state_nx = IDLE;
            tick_nx  = '0;
          end
        end else if (bit_end) begin
          stop_nx = 1'b1;
        end
      end
      RECOVER: begin
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shift_r  <= '0;
      perr_r   <= 1'b0;
    end else begin
      state    <= state_nx;
      tick_cnt <= tick_nx;
      bit_cnt  <= bit_nx;
      stop_cnt <= stop_nx;
      shift_r  <= shift_nx;
      perr_r   <= perr_nx;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_data       <= '0;
      o_rx_done    <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_rx_done <= done;
      if (done) begin
        o_data       <= shift_r;
        o_parity_err <= perr_r & PAR_EN;
        o_frame_err  <= ferr;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: instance a is 8N1, instance b is 8E2; random and directed frames.
module tb_uart_rx_frame;

`ifdef UART_RX_MAJORITY_EN
  localparam int SAMP = 8;
  localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
  localparam int SAMP = 7;
  localparam logic [7:0] GLITCH_EXP = 8'h04;
`endif

  logic       i_clock, i_reset, i_baud;
  logic       rx_a, rx_b;
  logic [7:0] data_a, data_b;
  logic       done_a, done_b, perr_a, perr_b, ferr_a, ferr_b;

  int checks   = 0;
  int failures = 0;
  logic [9:0] qa[$];
  logic [9:0] qb[$];
  logic [9:0] last_exp[2];

  uart_rx_frame u_a (
    .i_clock(i_clock), .i_reset(i_reset), .i_baud(i_baud), .i_rx(rx_a),
    .o_data(data_a), .o_rx_done(done_a), .o_parity_err(perr_a), .o_frame_err(ferr_a)
  );

  uart_rx_frame #(.NDATA_BITS(8), .NSTOP_BITS(2), .PARITY_MODE(2), .OVERSAMPLING(16)) u_b (
    .i_clock(i_clock), .i_reset(i_reset), .i_baud(i_baud), .i_rx(rx_b),
    .o_data(data_b), .o_rx_done(done_b), .o_parity_err(perr_b), .o_frame_err(ferr_b)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  initial begin
    int cyc;
    cyc = 0;
    i_baud = 1'b0;
    forever begin
      @(negedge i_clock);
      cyc++;
      i_baud = (cyc % 4 == 0);
    end
  end

  always @(negedge i_clock) begin
    if (done_a === 1'b1) qa.push_back({ferr_a, perr_a, data_a});
    if (done_b === 1'b1) qb.push_back({ferr_b, perr_b, data_b});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge i_clock); while (i_baud !== 1'b1);
    end
    #1;
  endtask

  task automatic drive(input int sel, input logic val, input int n);
    if (sel == 0) rx_a = val;
    else rx_b = val;
    if (n > 0) wait_ticks(n);
  endtask

  // Line-level description of a frame: start, 8 data LSB first, parity (b only), stop bit(s).
  task automatic send_frame(input int sel, input logic [7:0] d, input logic p,
                            input logic s0, input logic s1, input int gap);
    drive(sel, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive(sel, d[i], 16);
    if (sel == 1) drive(sel, p, 16);
    drive(sel, s0, 16);
    if (sel == 1) drive(sel, s1, 16);
    drive(sel, 1'b1, gap);
  endtask

  function automatic logic [9:0] model(input int sel, input logic [7:0] d, input logic p,
                                       input logic s0, input logic s1);
    logic pe, fe;
    if (sel == 0) begin
      pe = 1'b0;
      fe = !s0;
    end else begin
      pe = ((($countones(d) + int'(p)) % 2) == 1);
      fe = !(s0 && s1);
    end
    return {fe, pe, d};
  endfunction

  task automatic check_frame(input int sel, input logic [9:0] exp, input string tag);
    int n;
    logic [9:0] got;
    n = (sel == 0) ? qa.size() : qb.size();
    check({tag, "_pulses"}, 32'(n), 32'd1);
    if (n > 0) begin
      if (sel == 0) got = qa.pop_front();
      else got = qb.pop_front();
      check({tag, "_data"}, 32'(got[7:0]), 32'(exp[7:0]));
      check({tag, "_perr"}, 32'(got[8]), 32'(exp[8]));
      check({tag, "_ferr"}, 32'(got[9]), 32'(exp[9]));
    end
    if (sel == 0) begin
      check({tag, "_held"}, 32'({ferr_a, perr_a, data_a}), 32'(exp));
      qa.delete();
    end else begin
      check({tag, "_held"}, 32'({ferr_b, perr_b, data_b}), 32'(exp));
      qb.delete();
    end
    last_exp[sel] = exp;
  endtask

  initial begin
    logic [7:0] d;
    logic       p, s0, s1;
    int         gap;

    i_reset = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    last_exp[0] = '0;
    last_exp[1] = '0;
    repeat (3) @(negedge i_clock);
    check("rst_data", 32'(data_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_perr", 32'(perr_b), 32'd0);
    check("rst_ferr", 32'(ferr_b), 32'd0);
    i_reset = 1'b1;
    wait_ticks(4);

    // 0x55 8N1 with completion latency relative to the stop-bit sample tick
    d = 8'h55;
    drive(0, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive(0, d[i], 16);
    drive(0, 1'b1, SAMP);
    check("lat_before", 32'(done_a), 32'd0);
    wait_ticks(1);
    check("lat_rise", 32'(done_a), 32'd1);
    @(posedge i_clock);
    #1;
    check("lat_fall", 32'(done_a), 32'd0);
    wait_ticks(16 - SAMP - 1);
    check_frame(0, model(0, 8'h55, 1'b0, 1'b1, 1'b1), "f55");

    // stop bit low followed by a 40-bit-time break
    d = 8'h5A;
    drive(0, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive(0, d[i], 16);
    drive(0, 1'b0, 16 * 41);
    check_frame(0, model(0, 8'h5A, 1'b0, 1'b0, 1'b1), "brk");
    drive(0, 1'b1, 2);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1, 1);
    check_frame(0, model(0, 8'h3C, 1'b0, 1'b1, 1'b1), "f3c");

    // async reset in the middle of data bit 3
    drive(0, 1'b0, 16);
    for (int i = 0; i < 3; i++) drive(0, 1'b1, 16);
    drive(0, 1'b1, 7);
    #3;
    i_reset = 1'b0;
    #1;
    check("mrst_data", 32'(data_a), 32'd0);
    check("mrst_done", 32'(done_a), 32'd0);
    check("mrst_flags", 32'({ferr_a, perr_a}), 32'd0);
    @(negedge i_clock);
    i_reset = 1'b1;
    last_exp[0] = '0;
    last_exp[1] = '0;
    wait_ticks(3);
    check("mrst_nopulse", 32'(qa.size()), 32'd0);
    send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b1, 2);
    check_frame(0, model(0, 8'hFF, 1'b0, 1'b1, 1'b1), "fff");

    // 0x00 with a one-tick high glitch on bit 2 at the single-sample tick
    drive(0, 1'b0, 16);
    drive(0, 1'b0, 16);
    drive(0, 1'b0, 16);
    drive(0, 1'b0, 7);
    drive(0, 1'b1, 1);
    drive(0, 1'b0, 8);
    for (int i = 3; i < 8; i++) drive(0, 1'b0, 16);
    drive(0, 1'b1, 18);
    check_frame(0, {2'b00, GLITCH_EXP}, "glitch");

    for (int r = 0; r < 12; r++) begin
      d   = 8'($urandom);
      s0  = ($urandom_range(0, 4) != 0);
      gap = s0 ? $urandom_range(0, 2) : 2;
      send_frame(0, d, 1'b0, s0, 1'b1, gap);
      check_frame(0, model(0, d, 1'b0, s0, 1'b1), "rnd_a");
    end

    // instance b: even parity, two stop bits
    send_frame(1, 8'hA3, 1'b0, 1'b1, 1'b1, 1);
    check_frame(1, model(1, 8'hA3, 1'b0, 1'b1, 1'b1), "pa3_ok");
    send_frame(1, 8'hA3, 1'b1, 1'b1, 1'b1, 0);
    check_frame(1, model(1, 8'hA3, 1'b1, 1'b1, 1'b1), "pa3_bad");

    drive(1, 1'b0, 4);
    drive(1, 1'b1, 24);
    check("sglitch_nopulse", 32'(qb.size()), 32'd0);
    check("sglitch_held", 32'({ferr_b, perr_b, data_b}), 32'(last_exp[1]));
    send_frame(1, 8'h81, 1'b0, 1'b1, 1'b1, 1);
    check_frame(1, model(1, 8'h81, 1'b0, 1'b1, 1'b1), "f81");

    for (int r = 0; r < 12; r++) begin
      d   = 8'($urandom);
      p   = 1'($urandom);
      s0  = ($urandom_range(0, 5) != 0);
      s1  = ($urandom_range(0, 5) != 0);
      gap = (s0 && s1) ? $urandom_range(0, 2) : 2;
      send_frame(1, d, p, s0, s1, gap);
      check_frame(1, model(1, d, p, s0, s1), "rnd_b");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
